// File: rtl/sweep_controller.sv
// sweep_controller: drives a load/up/down counter through a Lo -> Hi -> Lo
// triangle for a programmable number of passes, checking every step the
// counter takes against an internally tracked expected value.
//
//  state  | meaning
//  -------+--------------------------------------------------------------
//  IDLE   | waiting for Start; rejects Start when Lo_Bound >= Hi_Bound
//  LOAD   | Load asserted with IN = Lo; counter holds Lo next cycle
//  UP     | counting up towards Hi; turns around at Hi with no dwell
//  DOWN   | counting down towards Lo; a pass completes on reaching Lo
module sweep_controller #(
    parameter int WIDTH = 5,
    parameter int CYC_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [WIDTH-1:0] Lo_Bound,
    input  logic [WIDTH-1:0] Hi_Bound,
    input  logic [CYC_W-1:0] Cycles,
    input  logic             Abort,
    input  logic [WIDTH-1:0] Counter,
    input  logic             High,
    input  logic             Low,
    output logic [WIDTH-1:0] IN,
    output logic             Load,
    output logic             Up,
    output logic             Down,
    output logic             Busy,
    output logic             Done,
    output logic             Error
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_UP, S_DOWN} state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] expected;
    logic [CYC_W-1:0] cycles_q;
    logic [CYC_W-1:0] remaining;

    logic start_ok;
    logic sweeping;
    logic mismatch;
    logic at_hi;
    logic at_lo;
    logic last_pass;

    assign start_ok  = Start && (Lo_Bound < Hi_Bound);
    assign sweeping  = (state == S_UP) || (state == S_DOWN);
    assign mismatch  = sweeping && (Counter != expected);
    assign at_hi     = (Counter == hi_q);
    assign at_lo     = (Counter == lo_q);
    // Cycles == 0 means run until Abort, so it never has a last pass.
    assign last_pass = (cycles_q != '0) && (remaining == CYC_W'(1));

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; Abort overrides completion and mismatch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (start_ok) next_state = S_LOAD;
            S_LOAD: next_state = S_UP;
            S_UP: begin
                if (mismatch)   next_state = S_IDLE;
                else if (at_hi) next_state = S_DOWN;
            end
            S_DOWN: begin
                if (mismatch)   next_state = S_IDLE;
                else if (at_lo) next_state = last_pass ? S_IDLE : S_UP;
            end
            default: next_state = S_IDLE;
        endcase
        if (Abort && (state != S_IDLE)) next_state = S_IDLE;
    end

    // Counter command decode; turnarounds happen in the same cycle as the compare.
    always_comb begin
        Load = 1'b0;
        Up   = 1'b0;
        Down = 1'b0;
        if (!Abort) begin
            case (state)
                S_LOAD: Load = 1'b1;
                S_UP: begin
                    if (!mismatch) begin
                        if (at_hi) Down = !Low;
                        else       Up   = !High;
                    end
                end
                S_DOWN: begin
                    if (!mismatch) begin
                        if (!at_lo)          Down = !Low;
                        else if (!last_pass) Up   = !High;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath: bounds capture, expected-value tracking, pass count and status pulses.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            lo_q      <= '0;
            hi_q      <= '0;
            cycles_q  <= '0;
            remaining <= '0;
            expected  <= '0;
            IN        <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Error     <= 1'b0;
        end else begin
            Busy  <= (next_state != S_IDLE);
            Done  <= 1'b0;
            Error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        lo_q      <= Lo_Bound;
                        hi_q      <= Hi_Bound;
                        cycles_q  <= Cycles;
                        remaining <= Cycles;
                        IN        <= Lo_Bound;
                    end else if (Start) begin
                        Error <= 1'b1;
                    end
                end
                S_LOAD: expected <= lo_q;
                S_UP: begin
                    if (!Abort) begin
                        if (mismatch)   Error    <= 1'b1;
                        else if (at_hi) expected <= expected - WIDTH'(1);
                        else            expected <= expected + WIDTH'(1);
                    end
                end
                S_DOWN: begin
                    if (!Abort) begin
                        if (mismatch) begin
                            Error <= 1'b1;
                        end else if (!at_lo) begin
                            expected <= expected - WIDTH'(1);
                        end else begin
                            if (cycles_q != '0) remaining <= remaining - CYC_W'(1);
                            if (last_pass) Done     <= 1'b1;
                            else           expected <= expected + WIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sweep_controller.sv
// Bench for sweep_controller: a behavioural 5-bit load/up/down counter closes
// the loop; a vector table covers full sweeps and rejected starts, followed by
// hand-written sequences for abort, counter stall and reset mid-sweep.
module tb_sweep_controller;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       Start = 1'b0;
    logic [4:0] Lo_Bound = '0;
    logic [4:0] Hi_Bound = '0;
    logic [3:0] Cycles = '0;
    logic       Abort = 1'b0;
    logic [4:0] Counter;
    logic       High;
    logic       Low;
    logic [4:0] IN;
    logic       Load;
    logic       Up;
    logic       Down;
    logic       Busy;
    logic       Done;
    logic       Error;

    logic [4:0] cnt = '0;
    logic       hold = 1'b0;

    int checks = 0;
    int errors = 0;

    sweep_controller #(.WIDTH(5), .CYC_W(4)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Lo_Bound(Lo_Bound),
        .Hi_Bound(Hi_Bound), .Cycles(Cycles), .Abort(Abort),
        .Counter(Counter), .High(High), .Low(Low), .IN(IN), .Load(Load),
        .Up(Up), .Down(Down), .Busy(Busy), .Done(Done), .Error(Error)
    );

    always #5 CLK = ~CLK;

    assign Counter = cnt;
    assign High    = (cnt == 5'd31);
    assign Low     = (cnt == 5'd0);

    // Counter model; hold freezes it for one edge to provoke a step mismatch.
    always @(posedge CLK) begin
        if (!hold) begin
            if (Load)      cnt <= IN;
            else if (Up)   cnt <= cnt + 5'd1;
            else if (Down) cnt <= cnt - 5'd1;
        end
    end

    // Command sanity on every cycle: one command at most, no Up at High, no Down at Low.
    always @(negedge CLK) begin
        if (RST) begin
            checks++;
            if ((Up && High) || (Down && Low) || ((int'(Load) + int'(Up) + int'(Down)) > 1)) begin
                errors++;
                $display("FAIL cmd_safety: Load=%0b Up=%0b Down=%0b High=%0b Low=%0b", Load, Up, Down, High, Low);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic [4:0] lo;
        logic [4:0] hi;
        logic [3:0] cyc;
        bit         exp_err;
        int         exp_done;
    } vec_t;

    vec_t vecs[6];

    // Expected triangle value k cycles into the sweep (k=0 is the first UP cycle).
    function automatic int tri_val(input int lo, input int hi, input int k);
        int d;
        int m;
        d = hi - lo;
        m = k % (2 * d);
        return (m <= d) ? lo + m : lo + 2 * d - m;
    endfunction

    initial begin
        int cycle;
        int err_seen;
        int trace_bad;
        int trace4[6];

        // Done lands 3 + 2*(Hi-Lo)*Cycles cycles after the Start cycle.
        vecs[0] = '{lo: 5'd2,  hi: 5'd5,  cyc: 4'd1, exp_err: 1'b0, exp_done: 9};
        vecs[1] = '{lo: 5'd0,  hi: 5'd31, cyc: 4'd2, exp_err: 1'b0, exp_done: 127};
        vecs[2] = '{lo: 5'd7,  hi: 5'd7,  cyc: 4'd1, exp_err: 1'b1, exp_done: 0};
        vecs[3] = '{lo: 5'd9,  hi: 5'd3,  cyc: 4'd1, exp_err: 1'b1, exp_done: 0};
        vecs[4] = '{lo: 5'd1,  hi: 5'd4,  cyc: 4'd3, exp_err: 1'b0, exp_done: 21};
        vecs[5] = '{lo: 5'd10, hi: 5'd12, cyc: 4'd1, exp_err: 1'b0, exp_done: 7};
        trace4 = '{4, 5, 6, 5, 4, 5};

        // Reset values.
        #12;
        check("reset_outputs", int'({IN, Load, Up, Down, Busy, Done, Error}), 0);
        RST = 1'b1;
        step();
        step();

        // Vector table.
        for (int v = 0; v < 6; v++) begin
            Lo_Bound = vecs[v].lo;
            Hi_Bound = vecs[v].hi;
            Cycles   = vecs[v].cyc;
            Start    = 1'b1;
            step();
            Start = 1'b0;
            cycle = 1;
            if (vecs[v].exp_err) begin
                check("rej_error", int'(Error), 1);
                check("rej_busy", int'(Busy), 0);
                check("rej_load", int'(Load), 0);
                step();
                check("rej_error_pulse", int'(Error), 0);
                check("rej_busy_after", int'(Busy), 0);
            end else begin
                check("load_cycle1", int'(Load), 1);
                check("in_cycle1", int'(IN), int'(vecs[v].lo));
                check("busy_cycle1", int'(Busy), 1);
                err_seen = 0;
                trace_bad = 0;
                while (!Done && cycle < 400) begin
                    step();
                    cycle++;
                    if (Error) err_seen++;
                    if (!Done && cnt != 5'(tri_val(vecs[v].lo, vecs[v].hi, cycle - 2)))
                        trace_bad++;
                end
                check("done_cycle", cycle, vecs[v].exp_done);
                check("no_error", err_seen, 0);
                check("trace_bad", trace_bad, 0);
                check("busy_at_done", int'(Busy), 0);
                check("end_at_lo", int'(cnt), int'(vecs[v].lo));
                step();
                check("done_pulse", int'(Done), 0);
            end
            step();
        end

        // Continuous sweep, aborted while counting up at 5.
        Lo_Bound = 5'd4; Hi_Bound = 5'd6; Cycles = 4'd0; Start = 1'b1;
        step();
        Start = 1'b0;
        trace_bad = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (int'(cnt) != trace4[i]) trace_bad++;
        end
        check("cont_trace", trace_bad, 0);
        check("cont_busy", int'(Busy), 1);
        check("cont_up_before_abort", int'(Up), 1);
        Abort = 1'b1;
        #1;
        check("abort_cmds", int'({Load, Up, Down}), 0);
        step();
        Abort = 1'b0;
        check("abort_busy", int'(Busy), 0);
        check("abort_done", int'(Done), 0);
        check("abort_error", int'(Error), 0);
        check("abort_cnt_held", int'(cnt), 5);
        step();

        // Counter stalls for one edge mid-UP.
        Lo_Bound = 5'd3; Hi_Bound = 5'd8; Cycles = 4'd1; Start = 1'b1;
        step();
        Start = 1'b0;
        step();
        step();
        hold = 1'b1;
        step();
        hold = 1'b0;
        check("stall_cnt", int'(cnt), 4);
        check("stall_cmds", int'({Load, Up, Down}), 0);
        step();
        check("stall_error", int'(Error), 1);
        check("stall_busy", int'(Busy), 0);
        step();
        check("stall_error_pulse", int'(Error), 0);
        step();

        // Reset asserted in DOWN, then a clean sweep ignoring a Start while busy.
        Lo_Bound = 5'd2; Hi_Bound = 5'd5; Cycles = 4'd1; Start = 1'b1;
        step();
        Start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("pre_reset_down", int'(Down), 1);
        RST = 1'b0;
        #1;
        check("rst_outputs", int'({IN, Load, Up, Down, Busy, Done, Error}), 0);
        #2;
        RST = 1'b1;
        step();
        Lo_Bound = 5'd1; Hi_Bound = 5'd3; Cycles = 4'd2; Start = 1'b1;
        step();
        Start = 1'b0;
        cycle = 1;
        step();
        step();
        cycle = 3;
        Lo_Bound = 5'd0; Hi_Bound = 5'd20; Cycles = 4'd5; Start = 1'b1;
        step();
        cycle++;
        Start = 1'b0;
        check("busy_start_no_error", int'(Error), 0);
        check("busy_start_busy", int'(Busy), 1);
        while (!Done && cycle < 400) begin
            step();
            cycle++;
        end
        check("restart_done_cycle", cycle, 11);
        check("restart_end_lo", int'(cnt), 1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
